// File: rtl/moore_seq_det.sv
`default_nettype none
// ============================================================================
//  Module   : moore_seq_det
//  Purpose  : Programmable serial pattern detector with a registered (Moore)
//             one-cycle match pulse, saturating match counter, overlapping
//             or non-overlapping detection and a sticky configuration error.
//  Revision : 1.0 - initial release
// ============================================================================
module moore_seq_det #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,       // asynchronous, active-low
  input  logic               x_valid,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               clr,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  // Longest legal pattern, expressed in the fill/length width.
  localparam logic [LEN_W-1:0]   c_max_len = LEN_W'(MAX_LEN);
  // Configuration loaded by reset: pattern 101, length 3, overlapping.
  localparam logic [MAX_LEN-1:0] c_rst_pat = MAX_LEN'(3'b101);
  localparam logic [LEN_W-1:0]   c_rst_len = LEN_W'(3);
  localparam logic [CNT_W-1:0]   c_cnt_max = '1;

  // Registered state
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_y;
  logic [CNT_W-1:0]   r_cnt;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic               r_err;

  // Next-state values
  logic [MAX_LEN-1:0] w_hist_nxt;
  logic [LEN_W-1:0]   w_fill_nxt;
  logic               w_y_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [MAX_LEN-1:0] w_pat_nxt;
  logic [LEN_W-1:0]   w_len_nxt;
  logic               w_ovl_nxt;
  logic               w_err_nxt;

  // Match datapath
  logic [MAX_LEN-1:0] w_hist_shift;
  logic [LEN_W-1:0]   w_fill_inc;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_match;

  // State register: async reset restores the default configuration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= '0;
      r_fill <= '0;
      r_y    <= 1'b0;
      r_cnt  <= '0;
      r_pat  <= c_rst_pat;
      r_len  <= c_rst_len;
      r_ovl  <= 1'b1;
      r_err  <= 1'b0;
    end else begin
      r_hist <= w_hist_nxt;
      r_fill <= w_fill_nxt;
      r_y    <= w_y_nxt;
      r_cnt  <= w_cnt_nxt;
      r_pat  <= w_pat_nxt;
      r_len  <= w_len_nxt;
      r_ovl  <= w_ovl_nxt;
      r_err  <= w_err_nxt;
    end
  end

  // Match evaluation on the history as it will look after accepting x.
  always_comb begin
    w_hist_shift = {r_hist[MAX_LEN-2:0], x};
    w_fill_inc   = (r_fill == c_max_len) ? c_max_len : r_fill + LEN_W'(1);
    w_mask       = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
    // A zero length means the detector is disabled.
    w_match = (r_len != '0) && (w_fill_inc >= r_len) &&
              (((w_hist_shift ^ r_pat) & w_mask) == '0);
  end

  // Next-state logic, priority clr > cfg_load > x_valid.
  always_comb begin
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    w_y_nxt    = 1'b0;
    w_cnt_nxt  = r_cnt;
    w_pat_nxt  = r_pat;
    w_len_nxt  = r_len;
    w_ovl_nxt  = r_ovl;
    w_err_nxt  = r_err;
    if (clr) begin
      // Configuration and cfg_err are deliberately left untouched.
      w_hist_nxt = '0;
      w_fill_nxt = '0;
      w_cnt_nxt  = '0;
    end else if (cfg_load) begin
      // New pattern restarts the fill count; the counter keeps its value.
      w_pat_nxt  = pat;
      w_ovl_nxt  = overlap;
      w_fill_nxt = '0;
      if (pat_len == '0) begin
        w_len_nxt = '0;
        w_err_nxt = 1'b1;
      end else if (pat_len > c_max_len) begin
        w_len_nxt = c_max_len;
        w_err_nxt = 1'b1;
      end else begin
        w_len_nxt = pat_len;
        w_err_nxt = 1'b0;
      end
    end else if (x_valid) begin
      w_hist_nxt = w_hist_shift;
      w_fill_nxt = w_fill_inc;
      if (w_match) begin
        w_y_nxt = 1'b1;
        if (r_cnt != c_cnt_max) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        // Non-overlapping mode requires a full fresh pattern after a hit.
        if (!r_ovl) begin
          w_fill_nxt = '0;
        end
      end
    end
  end

  // Outputs come straight from registers (Moore).
  always_comb begin
    y         = r_y;
    match_cnt = r_cnt;
    cfg_err   = r_err;
  end

endmodule
`default_nettype wire

// File: tb/tb_moore_seq_det.sv
`default_nettype none
// ============================================================================
//  Module   : tb_moore_seq_det
//  Purpose  : Scoreboard bench for moore_seq_det. A second instance with a
//             2-bit counter shares all inputs to observe saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_moore_seq_det;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       x_valid  = 1'b0;
  logic       x        = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] pat      = 8'h00;
  logic [3:0] pat_len  = 4'd0;
  logic       overlap  = 1'b0;
  logic       clr      = 1'b0;

  logic       y,   cfg_err;
  logic [7:0] match_cnt;
  logic       y_s, cfg_err_s;
  logic [1:0] cnt_s;

  typedef struct {
    logic  y;
    int    cnt;
    logic  err;
    string tag;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  moore_seq_det #(.MAX_LEN(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .cfg_load(cfg_load),
    .pat(pat), .pat_len(pat_len), .overlap(overlap), .clr(clr),
    .y(y), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );

  moore_seq_det #(.MAX_LEN(8), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .cfg_load(cfg_load),
    .pat(pat), .pat_len(pat_len), .overlap(overlap), .clr(clr),
    .y(y_s), .match_cnt(cnt_s), .cfg_err(cfg_err_s)
  );

  always #5 clk = ~clk;

  // Compare both instances against one expectation; the 2-bit counter
  // expectation is the full count saturated at 3.
  task automatic compare(input exp_t e);
    int es;
    es = (e.cnt > 3) ? 3 : e.cnt;
    n_vec++;
    if (y !== e.y || y_s !== e.y || match_cnt !== 8'(e.cnt) ||
        cnt_s !== 2'(es) || cfg_err !== e.err || cfg_err_s !== e.err) begin
      n_fail++;
      $display("FAIL %s: got y=%b/%b cnt=%0d cnt2=%0d err=%b/%b, want y=%b cnt=%0d cnt2=%0d err=%b",
               e.tag, y, y_s, match_cnt, cnt_s, cfg_err, cfg_err_s, e.y, e.cnt, es, e.err);
    end
  endtask

  // Monitor: each queued entry belongs to the edge just taken.
  initial begin : p_monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        compare(e);
      end
    end
  end

  task automatic drive(input bit c, input bit l, input bit v, input bit b,
                       input logic [7:0] p, input logic [3:0] ln, input bit o,
                       input string tag, input bit ey, input int ec, input bit ee);
    exp_t e;
    @(negedge clk);
    #1;
    clr = c; cfg_load = l; x_valid = v; x = b;
    pat = p; pat_len = ln; overlap = o;
    e.y = ey; e.cnt = ec; e.err = ee; e.tag = tag;
    q.push_back(e);
  endtask

  // Config pins carry junk during data cycles; they must be ignored.
  task automatic bitin(input bit b, input bit ey, input int ec, input bit ee, input string tag);
    drive(0, 0, 1, b, 8'h3C, 4'd0, 1'b0, tag, ey, ec, ee);
  endtask

  task automatic gap(input int ec, input bit ee, input string tag);
    drive(0, 0, 0, 1, 8'h3C, 4'd0, 1'b0, tag, 1'b0, ec, ee);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] ln, input bit o,
                     input int ec, input bit ee, input string tag);
    drive(0, 1, 0, 0, p, ln, o, tag, 1'b0, ec, ee);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic async_rst(input string tag);
    exp_t e;
    @(negedge clk);
    #1;
    clr = 0; cfg_load = 0; x_valid = 0; rst = 1'b0;
    #1;
    e.y = 1'b0; e.cnt = 0; e.err = 1'b0; e.tag = tag;
    compare(e);
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang, want finish");
    $fatal(1, "timeout");
  end

  initial begin : p_stim
    exp_t e;
    #2 rst = 1'b0;
    #10;
    e.y = 1'b0; e.cnt = 0; e.err = 1'b0; e.tag = "reset";
    compare(e);
    @(negedge clk);
    #1 rst = 1'b1;

    // Default pattern 101, overlapping
    bitin(1, 0, 0, 0, "ovl_b1");
    bitin(0, 0, 0, 0, "ovl_b2");
    bitin(1, 1, 1, 0, "ovl_b3");
    bitin(0, 0, 1, 0, "ovl_b4");
    bitin(1, 1, 2, 0, "ovl_b5");
    gap(2, 0, "ovl_gap");

    // Non-overlapping 101
    cfg(8'h05, 4'd3, 1'b0, 2, 0, "novl_cfg");
    bitin(1, 0, 2, 0, "novl_b1");
    bitin(0, 0, 2, 0, "novl_b2");
    bitin(1, 1, 3, 0, "novl_b3");
    bitin(0, 0, 3, 0, "novl_b4");
    bitin(1, 0, 3, 0, "novl_b5");

    // Full-length 8'hA5 with gaps
    cfg(8'hA5, 4'd8, 1'b1, 3, 0, "a5_cfg");
    bitin(1, 0, 3, 0, "a5_b1");
    bitin(0, 0, 3, 0, "a5_b2");
    gap(3, 0, "a5_gap1");
    bitin(1, 0, 3, 0, "a5_b3");
    bitin(0, 0, 3, 0, "a5_b4");
    bitin(0, 0, 3, 0, "a5_b5");
    gap(3, 0, "a5_gap2");
    bitin(1, 0, 3, 0, "a5_b6");
    bitin(0, 0, 3, 0, "a5_b7");
    gap(3, 0, "a5_gap3");
    bitin(1, 1, 4, 0, "a5_b8");
    gap(4, 0, "a5_gap4");

    // Counter saturation: clr then five overlapping 101 hits
    drive(1, 0, 0, 0, 8'h00, 4'd0, 1'b0, "sat_clr", 1'b0, 0, 1'b0);
    cfg(8'h05, 4'd3, 1'b1, 0, 0, "sat_cfg");
    bitin(1, 0, 0, 0, "sat_b1");
    bitin(0, 0, 0, 0, "sat_b2");
    bitin(1, 1, 1, 0, "sat_m1");
    bitin(0, 0, 1, 0, "sat_b4");
    bitin(1, 1, 2, 0, "sat_m2");
    bitin(0, 0, 2, 0, "sat_b6");
    bitin(1, 1, 3, 0, "sat_m3");
    bitin(0, 0, 3, 0, "sat_b8");
    bitin(1, 1, 4, 0, "sat_m4");
    bitin(0, 0, 4, 0, "sat_b10");
    bitin(1, 1, 5, 0, "sat_m5");

    // Zero length disables and flags; legal length clears the flag
    cfg(8'hFF, 4'd0, 1'b1, 5, 1, "len0_cfg");
    for (int i = 0; i < 4; i++) bitin(1, 0, 5, 1, "len0_ones");
    cfg(8'h03, 4'd2, 1'b1, 5, 0, "len2_cfg");
    bitin(1, 0, 5, 0, "len2_b1");
    bitin(1, 1, 6, 0, "len2_b2");
    bitin(1, 1, 7, 0, "len2_b3");

    // Oversized length clamps to 8 and flags
    cfg(8'hFF, 4'd12, 1'b1, 7, 1, "clamp_cfg");
    for (int i = 0; i < 7; i++) bitin(1, 0, 7, 1, "clamp_fill");
    bitin(1, 1, 8, 1, "clamp_b8");
    bitin(1, 1, 9, 1, "clamp_b9");

    // clr + cfg_load + x_valid together: clr wins, config unchanged
    cfg(8'h05, 4'd3, 1'b1, 9, 0, "prio_cfg");
    bitin(1, 0, 9, 0, "prio_b1");
    bitin(0, 0, 9, 0, "prio_b2");
    drive(1, 1, 1, 1, 8'hFF, 4'd0, 1'b0, "prio_all", 1'b0, 0, 1'b0);
    bitin(1, 0, 0, 0, "prio_a1");
    bitin(0, 0, 0, 0, "prio_a2");
    bitin(1, 1, 1, 0, "prio_a3");
    bitin(0, 0, 1, 0, "prio_a4");
    bitin(1, 1, 2, 0, "prio_a5");

    // Reset between 2nd and 3rd bit of 101, then reset during a pulse
    bitin(1, 0, 2, 0, "rst_p1");
    bitin(0, 0, 2, 0, "rst_p2");
    async_rst("rst_mid_pattern");
    bitin(1, 0, 0, 0, "rst_p3");
    bitin(0, 0, 0, 0, "rst_q2");
    bitin(1, 1, 1, 0, "rst_q3");
    async_rst("rst_during_pulse");
    bitin(1, 0, 0, 0, "rst_after");

    @(negedge clk);
    #1 x_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
